nand_target_emu: RTL and testbench
==================================

Name: nand_target_emu

Overview:
- Synthesizable single-LUN ONFI-style NAND target emulator. It is the responder end of the flash controller's NAND bus.
- Decodes CLE/ALE/WRN cycles sampled on CLK, which is the NAND clock. Keeps one page buffer and drives DQ/DQS/RB_N back.
- Used for FPGA loopback and fast sim in place of the full nand_model.
- Single-data-rate: one byte per CLK edge. DQS is a strobe toggle only.

Parameters:
- PAGE_BYTES, 64, page buffer depth in bytes (power of 2, 16..4096).
- T_RST, 32, busy cycles after FFh.
- T_R, 64, busy cycles after 30h page read.
- T_PROG, 128, busy cycles after 10h program.
- ID_WORD, 32'h2C_88_04_4B, ID bytes returned MSB first after 90h/00h.

Ports:
- CLK, in, 1: NAND clock; every input is sampled on its rising edge.
- RST, in, 1: synchronous, active-high reset.
- CEN, in, 1: chip enable, active low. While high, the bus is ignored and outputs are tristated.
- CLE, in, 1: command latch enable.
- ALE, in, 1: address latch enable.
- WRN, in, 1: 1 = host writes; 0 = host reads.
- WPN, in, 1: write protect, active low.
- DQ_IN, in, 8: host-driven data.
- DQ_OUT, out, 8: target-driven data.
- DQ_OE, out, 1: target drives DQ.
- DQS_OUT, out, 1: read strobe.
- DQS_OE, out, 1: target drives DQS.
- RB_N, out, 1: ready/busy (0 = busy).

Behaviour:
- Reset: DQ_OUT=00h, DQ_OE=0, DQS_OUT=0, DQS_OE=0, RB_N=1, state=IDLE, status=E0h (WPN ? 80h : 00h folded into bit7). Page buffer contents are not reset.
- Cycle decode (only when CEN=0):
  - CMD = CLE & ~ALE & WRN.
  - ADDR = ~CLE & ALE & WRN.
  - DIN = CLE & ALE & WRN.
  - DOUT = CLE & ALE & ~WRN.
  - Anything else is idle.
- States: IDLE, ADDR, DIN, BUSY, DOUT.
- FFh in any state, including BUSY: → BUSY for T_RST cycles. Aborts the current op, status=E0h.
- 70h in any state: sets out_sel=STATUS, → DOUT. Does not affect the busy counter or RB_N.
- While BUSY: only FFh/70h are honoured; other CMD/ADDR/DIN cycles are ignored.
- 90h: → ADDR expecting 1 byte. Address 00h sets out_sel=ID and byte index 0, → DOUT. Any other address value returns 00h bytes.
- 00h: → ADDR expecting 5 bytes. Bytes 0–1 form the column (little-endian, masked to log2(PAGE_BYTES)); bytes 2–4 are row, which is ignored. 30h then starts BUSY for T_R. On completion, out_sel=PAGE, col_ptr=column, → DOUT.
- 80h: → ADDR (5 bytes), then DIN. Each DIN cycle writes buf[col_ptr] and increments col_ptr. 10h starts BUSY for T_PROG.
  - If WPN=0, writes are discarded and status bit0 (FAIL)=1.
  - Otherwise FAIL=0.
- Commands not listed above return the block to IDLE with no effect.
- DOUT, one byte per DOUT cycle:
  - DQ_OUT is registered. It becomes valid 1 CLK after the DOUT-qualifying edge (latency 1).
  - DQ_OE=1 and DQS_OE=1 while in DOUT and CEN=0.
  - DQS_OUT toggles on each byte output.
- Read wrap rules:
  - Page reads wrap col_ptr at PAGE_BYTES-1 → 0.
  - ID reads past byte 3 return 00h.
  - Status repeats the current status.
- Status byte: bit7=WPN, bit6=RDY, bit5=ARDY (both = ~busy), bit0=FAIL, other bits 0.
- RB_N=0 exactly for the busy count cycles. It rises on the edge after the counter reaches 0.
- CEN high in any state: outputs go Hi-Z-enabled low (OE=0) on the next edge. The state and busy counter continue.
- An ADDR cycle beyond the expected count is ignored. A CMD during ADDR/DIN restarts decode from that command.
- A RST edge mid-busy or mid-transfer forces the reset values on the same edge.

Optional Feature:
- Macro: NAND_EMU_ERASE_EN.
- Defined: 60h followed by 3 ADDR bytes then D0h → BUSY for T_PROG. A sequential fill sets buf[i]=FFh, one entry per busy cycle, and T_PROG must be ≥ PAGE_BYTES. WPN=0 blocks the fill and sets FAIL.
- Undefined: 60h and D0h are treated as unsupported commands (→ IDLE, no effect).

Decomposition:
- Package nand_emu_pkg holds:
  - the state enum;
  - the out_sel enum (STATUS, ID, PAGE);
  - command constants CMD_RESET=FFh, CMD_STATUS=70h, CMD_ID=90h, CMD_READ=00h, CMD_READ_CFM=30h, CMD_PROG=80h, CMD_PROG_CFM=10h, CMD_ERASE=60h, CMD_ERASE_CFM=D0h;
  - status bit indices.
- One sub-module, nand_emu_pagebuf: single-port PAGE_BYTES×8 RAM with a registered read port (1-cycle latency, which sets the DOUT latency).

Test Plan:
- RST high 2 cycles → RB_N=1, DQ_OE=0, DQS_OE=0. Then 70h + 1 DOUT → DQ_OUT=E0h (WPN=1).
- 90h, ADDR 00h, 5 DOUT → 2Ch, 88h, 04h, 4Bh, 00h; DQS_OUT toggles 5 times.
- 80h, addr 04h/00h/00h/00h/00h, DIN A5h, 5Ah, 10h → RB_N low exactly 128 cycles. Then 00h, same address, 30h → RB_N low 64 cycles; DOUT → A5h, 5Ah.
- WPN=0 program of 3Ch at column 0 → status 01h; readback returns the prior byte.
- 00h with column 63, 30h; 3 DOUT → buf[63], buf[0], buf[1] (wrap).
- FFh issued 10 cycles into T_PROG busy → RB_N stays low 32 more cycles; status E0h afterwards. 70h during busy → 80h (WPN=1, RDY=0).

Source files
------------

// File: rtl/nand_emu_pkg.sv
// Shared types, command codes and status-byte layout for the NAND target emulator.
package nand_emu_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DIN, ST_BUSY, ST_DOUT} state_t;
    typedef enum logic [1:0] {SEL_STATUS, SEL_ID, SEL_PAGE} out_sel_t;
    typedef enum logic [2:0] {OP_NONE, OP_RESET, OP_READ, OP_PROG, OP_ERASE} busy_op_t;
    typedef enum logic [1:0] {PEND_ID, PEND_READ, PEND_PROG, PEND_ERASE} pend_t;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_STATUS    = 8'h70;
    localparam logic [7:0] CMD_ID        = 8'h90;
    localparam logic [7:0] CMD_READ      = 8'h00;
    localparam logic [7:0] CMD_READ_CFM  = 8'h30;
    localparam logic [7:0] CMD_PROG      = 8'h80;
    localparam logic [7:0] CMD_PROG_CFM  = 8'h10;
    localparam logic [7:0] CMD_ERASE     = 8'h60;
    localparam logic [7:0] CMD_ERASE_CFM = 8'hD0;

    localparam int SB_WP   = 7;
    localparam int SB_RDY  = 6;
    localparam int SB_ARDY = 5;
    localparam int SB_FAIL = 0;

    function automatic logic [7:0] status_byte(input logic wpn, input logic busy, input logic fail);
        logic [7:0] s;
        s          = 8'h00;
        s[SB_WP]   = wpn;
        s[SB_RDY]  = ~busy;
        s[SB_ARDY] = ~busy;
        s[SB_FAIL] = fail;
        return s;
    endfunction

endpackage

// File: rtl/nand_emu_pagebuf.sv
// Single-port page buffer; the read port is registered and only updates on a read enable.
module nand_emu_pagebuf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/nand_target_emu.sv
// Single-LUN NAND target emulator: decodes CLE/ALE/WRN cycles, keeps one page, answers status/ID/page reads.
// Define NAND_EMU_ERASE_EN to accept the 60h/D0h erase sequence (fills the page with FFh while busy).
module nand_target_emu
    import nand_emu_pkg::*;
#(
    parameter int          PAGE_BYTES = 64,
    parameter int          T_RST      = 32,
    parameter int          T_R        = 64,
    parameter int          T_PROG     = 128,
    parameter logic [31:0] ID_WORD    = 32'h2C88_044B
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CEN,
    input  logic       CLE,
    input  logic       ALE,
    input  logic       WRN,
    input  logic       WPN,
    input  logic [7:0] DQ_IN,
    output logic [7:0] DQ_OUT,
    output logic       DQ_OE,
    output logic       DQS_OUT,
    output logic       DQS_OE,
    output logic       RB_N,
    output state_t     dbg_state
);

    localparam int AW = $clog2(PAGE_BYTES);
    localparam int CW = 16;

    state_t        state;
    out_sel_t      out_sel;
    out_sel_t      sel_q;
    busy_op_t      busy_op;
    pend_t         pend;
    logic [CW-1:0] busy_cnt;
    logic [2:0]    addr_cnt;
    logic [2:0]    addr_need;
    logic [AW-1:0] col_ptr;
    logic [2:0]    id_idx;
    logic          fail;
    logic [7:0]    byte_q;
    logic          dqs_q;
    logic          oe_q;
    logic          rb_q;

    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    logic cyc_cmd, cyc_addr, cyc_din, cyc_dout;
    logic busy, addr_full, din_wr, dout_rd;

    assign cyc_cmd  = ~CEN &  CLE & ~ALE &  WRN;
    assign cyc_addr = ~CEN & ~CLE &  ALE &  WRN;
    assign cyc_din  = ~CEN &  CLE &  ALE &  WRN;
    assign cyc_dout = ~CEN &  CLE &  ALE & ~WRN;

    assign busy      = (busy_op != OP_NONE);
    assign addr_full = (addr_cnt == addr_need);
    assign din_wr    = cyc_din && state == ST_DIN && !busy;
    assign dout_rd   = cyc_dout && state == ST_DOUT;

    always_comb begin
        case (pend)
            PEND_ID:    addr_need = 3'd1;
            PEND_ERASE: addr_need = 3'd3;
            default:    addr_need = 3'd5;
        endcase
    end

    function automatic logic [7:0] id_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return ID_WORD[31:24];
            3'd1:    return ID_WORD[23:16];
            3'd2:    return ID_WORD[15:8];
            3'd3:    return ID_WORD[7:0];
            default: return 8'h00;
        endcase
    endfunction

`ifdef NAND_EMU_ERASE_EN
    logic [AW:0] fill_idx;
    logic        erase_ok;
    logic        fill_en;
    assign fill_en = (busy_op == OP_ERASE) && erase_ok && !fill_idx[AW];
`endif

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = col_ptr;
        ram_wdata = DQ_IN;
        if (!RST) begin
            if (din_wr && WPN) ram_we = 1'b1;
            if (dout_rd && out_sel == SEL_PAGE) ram_re = 1'b1;
`ifdef NAND_EMU_ERASE_EN
            if (fill_en) begin
                ram_we    = 1'b1;
                ram_addr  = fill_idx[AW-1:0];
                ram_wdata = 8'hFF;
            end
`endif
        end
    end

    nand_emu_pagebuf #(.DEPTH(PAGE_BYTES), .AW(AW)) u_pagebuf (
        .clk   (CLK),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            out_sel  <= SEL_STATUS;
            sel_q    <= SEL_STATUS;
            busy_op  <= OP_NONE;
            pend     <= PEND_ID;
            busy_cnt <= '0;
            addr_cnt <= 3'd0;
            col_ptr  <= '0;
            id_idx   <= 3'd0;
            fail     <= 1'b0;
            byte_q   <= 8'h00;
            dqs_q    <= 1'b0;
            oe_q     <= 1'b0;
            rb_q     <= 1'b1;
`ifdef NAND_EMU_ERASE_EN
            fill_idx <= '0;
            erase_ok <= 1'b0;
`endif
        end else begin
            oe_q <= ~CEN && state == ST_DOUT;

            // Busy timer runs independently of the decode state so status polling can interleave.
            if (busy) begin
                if (busy_cnt != '0) begin
                    busy_cnt <= busy_cnt - CW'(1);
                end else begin
                    busy_op <= OP_NONE;
                    rb_q    <= 1'b1;
                    if (busy_op == OP_READ) begin
                        out_sel <= SEL_PAGE;
                        state   <= ST_DOUT;
                    end else if (state == ST_BUSY) begin
                        state <= ST_IDLE;
                    end
                end
`ifdef NAND_EMU_ERASE_EN
                if (fill_en) fill_idx <= fill_idx + 1'b1;
`endif
            end

            if (cyc_addr && state == ST_ADDR && !busy && !addr_full) begin
                addr_cnt <= addr_cnt + 3'd1;
                if (addr_cnt == 3'd0) col_ptr <= AW'(DQ_IN);
                if (addr_cnt == 3'd1) col_ptr <= col_ptr | AW'({DQ_IN, 8'h00});
                if (pend == PEND_ID) begin
                    out_sel <= SEL_ID;
                    id_idx  <= (DQ_IN == 8'h00) ? 3'd0 : 3'd4;
                    state   <= ST_DOUT;
                end else if (pend == PEND_PROG && addr_cnt == 3'd4) begin
                    state <= ST_DIN;
                end
            end

            if (din_wr) col_ptr <= col_ptr + 1'b1;

            if (dout_rd) begin
                sel_q <= out_sel;
                dqs_q <= ~dqs_q;
                case (out_sel)
                    SEL_STATUS: byte_q <= status_byte(WPN, busy, fail);
                    SEL_ID: begin
                        byte_q <= id_byte(id_idx);
                        if (id_idx != 3'd4) id_idx <= id_idx + 3'd1;
                    end
                    default: col_ptr <= col_ptr + 1'b1;
                endcase
            end

            if (cyc_cmd) begin
                if (DQ_IN == CMD_RESET) begin
                    state    <= ST_BUSY;
                    busy_op  <= OP_RESET;
                    busy_cnt <= CW'(T_RST - 1);
                    rb_q     <= 1'b0;
                    fail     <= 1'b0;
                end else if (DQ_IN == CMD_STATUS) begin
                    out_sel <= SEL_STATUS;
                    state   <= ST_DOUT;
                end else if (!busy) begin
                    addr_cnt <= 3'd0;
                    case (DQ_IN)
                        CMD_ID: begin
                            state <= ST_ADDR;
                            pend  <= PEND_ID;
                        end
                        CMD_READ: begin
                            state   <= ST_ADDR;
                            pend    <= PEND_READ;
                            col_ptr <= '0;
                        end
                        CMD_PROG: begin
                            state   <= ST_ADDR;
                            pend    <= PEND_PROG;
                            col_ptr <= '0;
                        end
                        CMD_READ_CFM: begin
                            if (state == ST_ADDR && pend == PEND_READ && addr_full) begin
                                state    <= ST_BUSY;
                                busy_op  <= OP_READ;
                                busy_cnt <= CW'(T_R - 1);
                                rb_q     <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        CMD_PROG_CFM: begin
                            if (state == ST_DIN && pend == PEND_PROG) begin
                                state    <= ST_BUSY;
                                busy_op  <= OP_PROG;
                                busy_cnt <= CW'(T_PROG - 1);
                                rb_q     <= 1'b0;
                                fail     <= ~WPN;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
`ifdef NAND_EMU_ERASE_EN
                        CMD_ERASE: begin
                            state <= ST_ADDR;
                            pend  <= PEND_ERASE;
                        end
                        CMD_ERASE_CFM: begin
                            if (state == ST_ADDR && pend == PEND_ERASE && addr_full) begin
                                state    <= ST_BUSY;
                                busy_op  <= OP_ERASE;
                                busy_cnt <= CW'(T_PROG - 1);
                                rb_q     <= 1'b0;
                                fail     <= ~WPN;
                                erase_ok <= WPN;
                                fill_idx <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
`else
                        CMD_ERASE, CMD_ERASE_CFM: state <= ST_IDLE;
`endif
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign DQ_OUT    = (sel_q == SEL_PAGE) ? ram_rdata : byte_q;
    assign DQ_OE     = oe_q;
    assign DQS_OE    = oe_q;
    assign DQS_OUT   = dqs_q;
    assign RB_N      = rb_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_nand_target_emu.sv
// Directed bench for nand_target_emu: reset, status, ID, program/read, write protect, wrap, reset abort.
module tb_nand_target_emu;
    import nand_emu_pkg::*;

    logic       CLK = 1'b0;
    logic       RST, CEN, CLE, ALE, WRN, WPN;
    logic [7:0] DQ_IN;
    logic [7:0] DQ_OUT;
    logic       DQ_OE, DQS_OUT, DQS_OE, RB_N;
    state_t     dbg_state;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_dqs  = 1'b0;

    always #5 CLK = ~CLK;

    nand_target_emu dut (
        .CLK       (CLK),
        .RST       (RST),
        .CEN       (CEN),
        .CLE       (CLE),
        .ALE       (ALE),
        .WRN       (WRN),
        .WPN       (WPN),
        .DQ_IN     (DQ_IN),
        .DQ_OUT    (DQ_OUT),
        .DQ_OE     (DQ_OE),
        .DQS_OUT   (DQS_OUT),
        .DQS_OE    (DQS_OE),
        .RB_N      (RB_N),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus edge; inputs change on the falling edge, outputs are sampled on the next falling edge.
    task automatic bus_cycle(input logic cle, input logic ale, input logic wrn, input logic [7:0] d);
        CEN = 1'b0; CLE = cle; ALE = ale; WRN = wrn; DQ_IN = d;
        @(posedge CLK);
        @(negedge CLK);
        CLE = 1'b0; ALE = 1'b0; WRN = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] c);
        bus_cycle(1'b1, 1'b0, 1'b1, c);
    endtask

    task automatic addr5(input logic [7:0] col_lo);
        bus_cycle(1'b0, 1'b1, 1'b1, col_lo);
        for (int i = 0; i < 4; i++) bus_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic din(input logic [7:0] d);
        bus_cycle(1'b1, 1'b1, 1'b1, d);
    endtask

    task automatic dout(input string tag, input logic [7:0] exp);
        bus_cycle(1'b1, 1'b1, 1'b0, 8'h00);
        exp_dqs = ~exp_dqs;
        check({tag, "_dq"}, 32'(DQ_OUT), 32'(exp));
        check({tag, "_dqs"}, 32'(DQS_OUT), 32'(exp_dqs));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic measure_busy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (RB_N == 1'b0 && n < 1000) begin
            n++;
            @(negedge CLK);
        end
        check(tag, n, exp_cycles);
    endtask

    initial begin
        RST = 1'b1; CEN = 1'b1; CLE = 1'b0; ALE = 1'b0; WRN = 1'b1; WPN = 1'b1; DQ_IN = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_rbn", 32'(RB_N), 32'h1);
        check("rst_dqoe", 32'(DQ_OE), 32'h0);
        check("rst_dqsoe", 32'(DQS_OE), 32'h0);
        check("rst_dqout", 32'(DQ_OUT), 32'h00);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        RST = 1'b0;

        cmd(8'h70);
        dout("status_reset", 8'hE0);
        check("status_dqoe", 32'(DQ_OE), 32'h1);
        check("status_dqsoe", 32'(DQS_OE), 32'h1);
        CEN = 1'b1;
        @(negedge CLK);
        check("cen_dqoe", 32'(DQ_OE), 32'h0);
        check("cen_dqsoe", 32'(DQS_OE), 32'h0);

        cmd(8'h90);
        check("id_state_addr", 32'(dbg_state), 32'(ST_ADDR));
        bus_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        dout("id0", 8'h2C);
        dout("id1", 8'h88);
        dout("id2", 8'h04);
        dout("id3", 8'h4B);
        dout("id4", 8'h00);

        cmd(8'h90);
        cmd(8'h55);
        check("unsupported_idle", 32'(dbg_state), 32'(ST_IDLE));

        cmd(8'h80);
        addr5(8'h04);
        din(8'hA5);
        din(8'h5A);
        cmd(8'h10);
        measure_busy("prog_busy", 128);
        cmd(8'h00);
        addr5(8'h04);
        cmd(8'h30);
        measure_busy("read_busy", 64);
        dout("read_c4", 8'hA5);
        dout("read_c5", 8'h5A);

        cmd(8'h80);
        addr5(8'h3E);
        din(8'h11);
        din(8'h22);
        din(8'h33);
        din(8'h44);
        cmd(8'h10);
        measure_busy("prog2_busy", 128);

        WPN = 1'b0;
        cmd(8'h80);
        addr5(8'h00);
        din(8'h3C);
        cmd(8'h10);
        cmd(8'h70);
        dout("status_wp", 8'h01);
        measure_busy("prog_wp_busy", 126);
        WPN = 1'b1;
        cmd(8'h00);
        addr5(8'h00);
        cmd(8'h30);
        measure_busy("read_wp_busy", 64);
        dout("read_wp_c0", 8'h33);

        cmd(8'h00);
        addr5(8'h3F);
        cmd(8'h30);
        measure_busy("read_wrap_busy", 64);
        dout("wrap_c63", 8'h22);
        dout("wrap_c0", 8'h33);
        dout("wrap_c1", 8'h44);

        cmd(8'h80);
        addr5(8'h08);
        din(8'h77);
        cmd(8'h10);
        idle(7);
        cmd(8'h70);
        dout("status_busy", 8'h80);
        cmd(8'hFF);
        measure_busy("reset_abort_busy", 32);
        cmd(8'h70);
        dout("status_after_reset", 8'hE0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
